// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: states, regime codes and per-state datapath control words
// for datapath_mode_arbiter.
package dp_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GRANT,
    UPD_LOAD,
    UPD_APPLY,
    UPD_SETTLE,
    CNT_RUN,
    CNT_WRAP,
    ENUM_WAIT,
    ENUM_A6,
    ENUM_A2,
    ENUM_A0,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    R_OFF   = 2'd0,
    R_ENUM  = 2'd1,
    R_COUNT = 2'd2,
    R_UPD   = 2'd3
  } regime_t;

  typedef struct packed {
    logic       y_en;
    logic       y_upd;
    logic [1:0] y_select_next;
    logic       s_en;
    logic       s_sub;
    logic [1:0] s_step;
    logic       s_zero;
  } ctrl_word_t;

  localparam ctrl_word_t CW_OFF =
    '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
  localparam ctrl_word_t CW_UPD_LOAD =
    '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
  localparam ctrl_word_t CW_UPD_APPLY =
    '{1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0};
  localparam ctrl_word_t CW_CNT_RUN =
    '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0};
  localparam ctrl_word_t CW_CNT_WRAP =
    '{1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 2'd1, 1'b0};
  localparam ctrl_word_t CW_ENUM_WAIT =
    '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1};
  localparam ctrl_word_t CW_ENUM_A6 =
    '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1};
  localparam ctrl_word_t CW_ENUM_A2 =
    '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0};
  localparam ctrl_word_t CW_ENUM_A0 =
    '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1};

  function automatic ctrl_word_t ctrl_of(input state_t s);
    ctrl_word_t w;
    w = CW_OFF;
    case (s)
      UPD_LOAD:  w = CW_UPD_LOAD;
      UPD_APPLY: w = CW_UPD_APPLY;
      CNT_RUN:   w = CW_CNT_RUN;
      CNT_WRAP:  w = CW_CNT_WRAP;
      ENUM_WAIT: w = CW_ENUM_WAIT;
      ENUM_A6:   w = CW_ENUM_A6;
      ENUM_A2:   w = CW_ENUM_A2;
      ENUM_A0:   w = CW_ENUM_A0;
      default:   w = CW_OFF;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/datapath_mode_arbiter_rr_pick.sv
// rr_pick: combinational priority pick rotated to start at i_ptr.
// Ports: i_elig, i_ptr in; o_onehot, o_idx, o_any out.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    w_j      = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_elig[w_j]) begin
        o_any         = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
      end
    end
  end

endmodule

// File: rtl/datapath_mode_arbiter.sv
// datapath_mode_arbiter: grants the shared y/s datapath to one requester
// and sequences its control word (UPD/COUNT/ENUM) until done.
// In: clk, rst_n, req, req_mode, req_hold, s_is_zero.
// Out: gnt, done, busy, regime, active, y_en, y_upd, y_select_next,
//      s_en, s_sub, s_step, s_zero (all registered).
// ARB_FIXED_PRIO_EN: lowest index wins, pointer held at 0.
import dp_ctrl_pkg::*;

module datapath_mode_arbiter #(
  parameter int NREQ    = 3,
  parameter int CNT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [NREQ-1:0]   req_hold,
  input  logic              s_is_zero,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [1:0]        regime,
  output logic              active,
  output logic              y_en,
  output logic              y_upd,
  output logic [1:0]        y_select_next,
  output logic              s_en,
  output logic              s_sub,
  output logic [1:0]        s_step,
  output logic              s_zero
);

  localparam int IW = $clog2(NREQ);

  state_t          r_state;
  state_t          w_nxt;
  logic [IW-1:0]   r_win;
  logic [IW-1:0]   r_ptr;
  logic [1:0]      r_mode;
  logic [7:0]      r_cnt;
  logic [1:0]      r_tmr;
  ctrl_word_t      r_word;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic [1:0]      r_regime;
  logic            r_active;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_pick_oh;
  logic [IW-1:0]   w_pick_idx;
  logic            w_any;
  logic [1:0]      w_pick_mode;
  logic            w_hold;
  logic [IW-1:0]   w_win;
  logic [1:0]      w_mode;
  logic [NREQ-1:0] w_win_oh;
  logic            w_cnt_hit;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req[i] & (req_mode[2*i +: 2] != R_OFF);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_any)
  );

  always_comb begin
    w_pick_mode = '0;
    w_hold      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_oh[i]) w_pick_mode = req_mode[2*i +: 2];
      if (r_win == IW'(i)) w_hold = req_hold[i];
    end
  end

  // In IDLE the fresh pick is what the next state will present.
  always_comb begin
    w_win    = (r_state == IDLE) ? w_pick_idx : r_win;
    w_mode   = (r_state == IDLE) ? w_pick_mode : r_mode;
    w_win_oh = '0;
    w_win_oh[w_win] = 1'b1;
  end

  // True on the CNT_MAX-th cycle spent in CNT_RUN/CNT_WRAP.
  assign w_cnt_hit = ({1'b0, r_cnt} + 9'd1) >= 9'(CNT_MAX);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_any) w_nxt = GRANT;
      GRANT: begin
        if (r_mode == R_UPD)        w_nxt = UPD_LOAD;
        else if (r_mode == R_COUNT) w_nxt = CNT_RUN;
        else if (r_mode == R_ENUM)  w_nxt = ENUM_WAIT;
        else                        w_nxt = DONE;
      end
      UPD_LOAD:   w_nxt = UPD_APPLY;
      UPD_APPLY:  w_nxt = UPD_SETTLE;
      UPD_SETTLE: w_nxt = DONE;
      CNT_RUN: begin
        if (w_cnt_hit)    w_nxt = DONE;
        else if (!w_hold) w_nxt = DONE;
        else if (s_is_zero) w_nxt = CNT_WRAP;
      end
      CNT_WRAP: begin
        if (w_cnt_hit)   w_nxt = DONE;
        else if (w_hold) w_nxt = CNT_RUN;
        else             w_nxt = DONE;
      end
      ENUM_WAIT: if (!w_hold) w_nxt = ENUM_A6;
      ENUM_A6:   w_nxt = ENUM_A2;
      ENUM_A2:   if (r_tmr == 2'd0) w_nxt = ENUM_A0;
      ENUM_A0:   if (r_tmr == 2'd0) w_nxt = DONE;
      DONE:      w_nxt = IDLE;
      default:   w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_win    <= '0;
      r_ptr    <= '0;
      r_mode   <= '0;
      r_cnt    <= '0;
      r_tmr    <= '0;
      r_word   <= CW_OFF;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_regime <= '0;
      r_active <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && w_any) begin
        r_win  <= w_pick_idx;
        r_mode <= w_pick_mode;
      end
      if (r_state == CNT_RUN || r_state == CNT_WRAP) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= '0;
      end
      // Dwell timer: A2 stays 2 cycles, A0 stays 3.
      if (w_nxt == ENUM_A2 && r_state != ENUM_A2) begin
        r_tmr <= 2'd1;
      end else if (w_nxt == ENUM_A0 && r_state != ENUM_A0) begin
        r_tmr <= 2'd2;
      end else if (r_tmr != 2'd0) begin
        r_tmr <= r_tmr - 2'd1;
      end
`ifdef ARB_FIXED_PRIO_EN
      r_ptr <= '0;
`else
      if (r_state == DONE) begin
        r_ptr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
      end
`endif
      r_word   <= ctrl_of(w_nxt);
      r_gnt    <= (w_nxt == IDLE) ? '0 : w_win_oh;
      r_done   <= (w_nxt == DONE) ? w_win_oh : '0;
      r_busy   <= (w_nxt != IDLE);
      r_regime <= (w_nxt == IDLE) ? 2'd0 : w_mode;
      r_active <= (w_nxt == ENUM_A6) || (w_nxt == ENUM_A2) ||
                  (w_nxt == ENUM_A0);
    end
  end

  assign gnt           = r_gnt;
  assign done          = r_done;
  assign busy          = r_busy;
  assign regime        = r_regime;
  assign active        = r_active;
  assign y_en          = r_word.y_en;
  assign y_upd         = r_word.y_upd;
  assign y_select_next = r_word.y_select_next;
  assign s_en          = r_word.s_en;
  assign s_sub         = r_word.s_sub;
  assign s_step        = r_word.s_step;
  assign s_zero        = r_word.s_zero;

endmodule

// File: tb/tb_datapath_mode_arbiter.sv
// tb_datapath_mode_arbiter: directed stimulus with a queued scoreboard
// popped by a negedge monitor on every busy cycle.
module tb_datapath_mode_arbiter;

  localparam int NREQ = 3;

  // control word: y_en,y_upd,ysel[1:0],s_en,s_sub,s_step[1:0],s_zero
  localparam logic [8:0] W0 = 9'b0_0_00_0_0_00_0;
  localparam logic [8:0] UL = 9'b1_0_00_0_0_00_0;
  localparam logic [8:0] UA = 9'b1_1_01_1_1_01_0;
  localparam logic [8:0] CR = 9'b0_0_00_1_1_01_0;
  localparam logic [8:0] CW = 9'b1_0_10_1_1_01_0;
  localparam logic [8:0] EW = 9'b0_0_00_0_1_10_1;
  localparam logic [8:0] E6 = 9'b0_0_00_1_1_10_1;
  localparam logic [8:0] E2 = 9'b0_0_00_1_1_10_0;
  localparam logic [8:0] E0 = 9'b0_0_00_1_1_10_1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [5:0]      req_mode;
  logic [NREQ-1:0] req_hold;
  logic            s_is_zero;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            busy;
  logic [1:0]      regime;
  logic            active;
  logic            y_en;
  logic            y_upd;
  logic [1:0]      y_select_next;
  logic            s_en;
  logic            s_sub;
  logic [1:0]      s_step;
  logic            s_zero;

  datapath_mode_arbiter #(
    .NREQ    (NREQ),
    .CNT_MAX (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_mode      (req_mode),
    .req_hold      (req_hold),
    .s_is_zero     (s_is_zero),
    .gnt           (gnt),
    .done          (done),
    .busy          (busy),
    .regime        (regime),
    .active        (active),
    .y_en          (y_en),
    .y_upd         (y_upd),
    .y_select_next (y_select_next),
    .s_en          (s_en),
    .s_sub         (s_sub),
    .s_step        (s_step),
    .s_zero        (s_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] v;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  int          n_pass = 0;
  int          n_tot  = 0;
  logic [17:0] got;

  assign got = {gnt, done, regime, active, y_en, y_upd, y_select_next,
                s_en, s_sub, s_step, s_zero};

  always @(negedge clk) begin
    if (rst_n && busy) begin
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected busy got=%05h exp=none", got);
      end else begin
        m_e = exp_q.pop_front();
        if (got === m_e.v) n_pass++;
        else $display("FAIL t%0d out got=%05h exp=%05h", m_e.t, got, m_e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int t, input logic [2:0] g,
                      input logic [2:0] d, input logic [1:0] r,
                      input logic a, input logic [8:0] w);
    exp_t e;
    e.v = {g, d, r, a, w};
    e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic push_upd(input int t, input logic [2:0] g);
    push(t, g, 3'b000, 2'd3, 1'b0, W0);
    push(t, g, 3'b000, 2'd3, 1'b0, UL);
    push(t, g, 3'b000, 2'd3, 1'b0, UA);
    push(t, g, 3'b000, 2'd3, 1'b0, W0);
    push(t, g, g,      2'd3, 1'b0, W0);
  endtask

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] x);
    n_tot++;
    if (g === x) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, g, x);
  endtask

  task automatic wait_idle(input int t, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (!busy && exp_q.size() == 0) ok = 1'b1;
      else tick();
    end
    n_tot++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL t%0d drain busy=%0b left=%0d exp=0", t, busy,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input int t);
    rst_n = 1'b0;
    #1;
    chk($sformatf("t%0d rst_out", t), 32'(got), 32'h0);
    chk($sformatf("t%0d rst_busy", t), 32'(busy), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk($sformatf("t%0d idle_out", t), 32'(got), 32'h0);
    chk($sformatf("t%0d idle_busy", t), 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_mode  = '0;
    req_hold  = '0;
    s_is_zero = 1'b0;
    tick();
    tick();
    chk("t0 rst_out", 32'(got), 32'h0);
    chk("t0 rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // t1: ENUM, reset lands in the first ENUM_A2 cycle
    req = 3'b001; req_mode = 6'b000001; req_hold = 3'b000;
    push(1, 3'b001, 3'b000, 2'd1, 1'b0, W0);
    push(1, 3'b001, 3'b000, 2'd1, 1'b0, EW);
    push(1, 3'b001, 3'b000, 2'd1, 1'b1, E6);
    tick(); req = '0;
    tick(); tick(); tick();
    chk("t1 a2_active", 32'(active), 32'h1);
    chk("t1 a2_word", 32'(got[8:0]), 32'(E2));
    do_reset(1);
    chk("t1 queue", 32'(exp_q.size()), 32'h0);
    req_mode = '0;

    // t2: UPD, late mode change and req drop ignored
    req = 3'b001; req_mode = 6'b000011;
    push_upd(2, 3'b001);
    tick(); req = '0; req_mode = 6'b000010;
    wait_idle(2, 20);
    req_mode = '0;

    // t3: COUNT, zero on third run cycle, hold drops in CNT_WRAP
    req = 3'b001; req_mode = 6'b000010; req_hold = 3'b001;
    push(3, 3'b001, 3'b000, 2'd2, 1'b0, W0);
    push(3, 3'b001, 3'b000, 2'd2, 1'b0, CR);
    push(3, 3'b001, 3'b000, 2'd2, 1'b0, CR);
    push(3, 3'b001, 3'b000, 2'd2, 1'b0, CR);
    push(3, 3'b001, 3'b000, 2'd2, 1'b0, CW);
    push(3, 3'b001, 3'b001, 2'd2, 1'b0, W0);
    tick(); req = '0;
    tick(); tick(); tick(); s_is_zero = 1'b1;
    tick(); s_is_zero = 1'b0; req_hold = '0;
    wait_idle(3, 20);

    // t3b: hold low beats s_is_zero in CNT_RUN
    req = 3'b001; req_mode = 6'b000010; req_hold = 3'b001;
    s_is_zero = 1'b1;
    push(13, 3'b001, 3'b000, 2'd2, 1'b0, W0);
    push(13, 3'b001, 3'b000, 2'd2, 1'b0, CR);
    push(13, 3'b001, 3'b000, 2'd2, 1'b0, CW);
    push(13, 3'b001, 3'b000, 2'd2, 1'b0, CR);
    push(13, 3'b001, 3'b001, 2'd2, 1'b0, W0);
    tick(); req = '0;
    tick(); tick(); tick(); req_hold = '0;
    wait_idle(13, 20);
    s_is_zero = 1'b0;

    // t4: COUNT with hold stuck high, forced DONE after 4 cycles
    req = 3'b001; req_mode = 6'b000010; req_hold = 3'b001;
    push(4, 3'b001, 3'b000, 2'd2, 1'b0, W0);
    for (int i = 0; i < 4; i++) push(4, 3'b001, 3'b000, 2'd2, 1'b0, CR);
    push(4, 3'b001, 3'b001, 2'd2, 1'b0, W0);
    tick(); req = '0;
    wait_idle(4, 20);
    req_hold = '0;

    // t5: ENUM, hold high 3 cycles then low
    req = 3'b001; req_mode = 6'b000001; req_hold = 3'b001;
    push(5, 3'b001, 3'b000, 2'd1, 1'b0, W0);
    push(5, 3'b001, 3'b000, 2'd1, 1'b0, EW);
    push(5, 3'b001, 3'b000, 2'd1, 1'b0, EW);
    push(5, 3'b001, 3'b000, 2'd1, 1'b1, E6);
    push(5, 3'b001, 3'b000, 2'd1, 1'b1, E2);
    push(5, 3'b001, 3'b000, 2'd1, 1'b1, E2);
    push(5, 3'b001, 3'b000, 2'd1, 1'b1, E0);
    push(5, 3'b001, 3'b000, 2'd1, 1'b1, E0);
    push(5, 3'b001, 3'b000, 2'd1, 1'b1, E0);
    push(5, 3'b001, 3'b001, 2'd1, 1'b0, W0);
    tick(); req = '0;
    tick(); tick(); req_hold = '0;
    wait_idle(5, 30);

    // t6: three UPD requesters held, fresh pointer
    do_reset(6);
    req = 3'b111; req_mode = 6'b111111;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push_upd(6, 3'b001);
`else
    push_upd(6, 3'b001);
    push_upd(6, 3'b010);
    push_upd(6, 3'b100);
    push_upd(6, 3'b001);
`endif
    for (int i = 0; i < 20; i++) tick();
    req = '0;
    wait_idle(6, 40);

    // t7: mode 0 is never granted
    req = 3'b001; req_mode = 6'b000000;
    tick(); tick(); tick();
    chk("t7 mode0_busy", 32'(busy), 32'h0);
    req = 3'b011; req_mode = 6'b001100;
    push_upd(7, 3'b010);
    tick(); req = '0;
    wait_idle(7, 20);
    req_mode = '0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
